// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, MixColumns coefficient rows and
// the sequencer state type used by mix_columns_seq.
package aes_pkg;

    // First row of each MixColumns matrix; the other rows are rotations.
    // Index 0 multiplies a0 when producing b0.
    localparam logic [0:3][7:0] FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [0:3][7:0] INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product built from an xtime chain and XORs only.
    // Callers pass constant coefficients, so the unused terms fold away.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p1, p2, p3, p4, p5, p6, p7;
        p1 = xtime(a);
        p2 = xtime(p1);
        p3 = xtime(p2);
        p4 = xtime(p3);
        p5 = xtime(p4);
        p6 = xtime(p5);
        p7 = xtime(p6);
        return ({8{k[0]}} & a)  ^ ({8{k[1]}} & p1) ^ ({8{k[2]}} & p2) ^
               ({8{k[3]}} & p3) ^ ({8{k[4]}} & p4) ^ ({8{k[5]}} & p5) ^
               ({8{k[6]}} & p6) ^ ({8{k[7]}} & p7);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column.
// Byte a0 sits in col[31:24]; result uses the same byte order.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic        mode,
    output logic [31:0] result
);

    logic [0:3][7:0] a;
    logic [0:3][7:0] fwd_b;
    logic [0:3][7:0] inv_b;

    assign a = col;

    // Both transforms use constant coefficients and are muxed afterwards,
    // which keeps each multiplier a fixed XOR network.
    for (genvar i = 0; i < 4; i++) begin : g_row
        localparam int K0 = (4 - i) % 4;
        localparam int K1 = (5 - i) % 4;
        localparam int K2 = (6 - i) % 4;
        localparam int K3 = (7 - i) % 4;

        assign fwd_b[i] = gf_mul(a[0], FWD_COEF[K0]) ^ gf_mul(a[1], FWD_COEF[K1]) ^
                          gf_mul(a[2], FWD_COEF[K2]) ^ gf_mul(a[3], FWD_COEF[K3]);
        assign inv_b[i] = gf_mul(a[0], INV_COEF[K0]) ^ gf_mul(a[1], INV_COEF[K1]) ^
                          gf_mul(a[2], INV_COEF[K2]) ^ gf_mul(a[3], INV_COEF[K3]);
    end

    assign result = mode ? inv_b : fwd_b;

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns engine. A state is accepted into a working
// register, transformed PARALLEL_COLS columns per cycle in place over
// 4/PARALLEL_COLS cycles, then held on OUT until downstream takes it.
// Legal parameters: BLOCK_LENGTH = 128, PARALLEL_COLS in {1, 2, 4}.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH  = 128,
    parameter int PARALLEL_COLS = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    MODE,
    input  logic                    BYPASS,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    localparam int         GROUPS   = 4 / PARALLEL_COLS;
    localparam logic [1:0] LAST_CNT = 2'(GROUPS - 1);

    mc_state_t       state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            mode_q, bypass_q;
    logic [0:3][31:0] work_q, work_d;   // index c is column c (bytes s[4c..4c+3])
    logic            load, busy, in_ready, out_valid;

    logic [31:0] col_in  [PARALLEL_COLS];
    logic [31:0] col_out [PARALLEL_COLS];

    // One column engine per lane; lane g works on column cnt*P + g.
    for (genvar g = 0; g < PARALLEL_COLS; g++) begin : g_lane
        logic [1:0] sel;
        assign sel       = 2'(int'(cnt_q) * PARALLEL_COLS + g);
        assign col_in[g] = work_q[sel];

        mix_single_column u_col (
            .col    (col_in[g]),
            .mode   (mode_q),
            .result (col_out[g])
        );
    end

    // Only the active group is rewritten; bypass keeps every column intact.
    for (genvar c = 0; c < 4; c++) begin : g_col
        assign work_d[c] = (busy && !bypass_q && cnt_q == 2'(c / PARALLEL_COLS))
                         ? col_out[c % PARALLEL_COLS] : work_q[c];
    end

    // Next-state, group counter and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (IN_VALID) begin
                    load    = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = OUT_READY;
                if (OUT_READY) begin
                    if (IN_VALID) begin
                        load    = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and group counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: non-blocking assignments so every register here samples the
        // pre-edge values of the others, independent of statement order.
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Working register plus the MODE/BYPASS captured at acceptance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the working register drives OUT directly, so it is reset
            // to keep a discarded result from lingering on the output.
            work_q   <= '0;
            mode_q   <= 1'b0;
            bypass_q <= 1'b0;
        end else if (load) begin
            work_q   <= IN;
            mode_q   <= MODE;
            bypass_q <= BYPASS;
        end else if (busy) begin
            work_q   <= work_d;
        end
    end

    assign OUT       = work_q;
    assign OUT_VALID = out_valid;
    assign IN_READY  = in_ready;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (P = 1, 2, 4) share the clock,
// reset and data inputs; each has its own handshake. A matrix-level model
// predicts results and handshake timing, and a negedge process compares it
// with every instance each cycle. Directed vectors pin literal results.
module tb_mix_columns_seq;

    localparam int NI = 3;
    localparam int PC [NI] = '{1, 2, 4};

    localparam logic [7:0] FWD_M [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                            '{8'h01, 8'h02, 8'h03, 8'h01},
                                            '{8'h01, 8'h01, 8'h02, 8'h03},
                                            '{8'h03, 8'h01, 8'h01, 8'h02}};
    localparam logic [7:0] INV_M [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                            '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                            '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                            '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic         mode, bypass;
    logic         in_valid    [NI];
    logic         out_ready   [NI];
    logic         in_ready_s  [NI];
    logic         out_valid_s [NI];
    logic [127:0] out_s       [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.BLOCK_LENGTH(128), .PARALLEL_COLS(1)) u_p1 (
        .CLK(clk), .RST_N(rst_n), .IN(in_data), .IN_VALID(in_valid[0]),
        .IN_READY(in_ready_s[0]), .MODE(mode), .BYPASS(bypass),
        .OUT(out_s[0]), .OUT_VALID(out_valid_s[0]), .OUT_READY(out_ready[0]));

    mix_columns_seq #(.BLOCK_LENGTH(128), .PARALLEL_COLS(2)) u_p2 (
        .CLK(clk), .RST_N(rst_n), .IN(in_data), .IN_VALID(in_valid[1]),
        .IN_READY(in_ready_s[1]), .MODE(mode), .BYPASS(bypass),
        .OUT(out_s[1]), .OUT_VALID(out_valid_s[1]), .OUT_READY(out_ready[1]));

    mix_columns_seq #(.BLOCK_LENGTH(128), .PARALLEL_COLS(4)) u_p4 (
        .CLK(clk), .RST_N(rst_n), .IN(in_data), .IN_VALID(in_valid[2]),
        .IN_READY(in_ready_s[2]), .MODE(mode), .BYPASS(bypass),
        .OUT(out_s[2]), .OUT_VALID(out_valid_s[2]), .OUT_READY(out_ready[2]));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Carry-less product followed by polynomial reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int bitn = 14; bitn >= 8; bitn--)
            if (p[bitn]) p = p ^ (15'h11b << (bitn - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic m, input logic bp);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   acc;
        if (bp) return s;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8 * (4 * c + k) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m ? INV_M[row][k] : FWD_M[row][k], a[k]);
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Per instance: cycles left until the in-flight result appears, whether
    // a result is being presented, and its value.
    int           m_left [NI];
    bit           m_hold [NI];
    logic [127:0] m_pend [NI];
    logic [127:0] m_out  [NI];

    function automatic bit m_ready(input int i);
        return (m_left[i] == 0 && !m_hold[i]) || (m_hold[i] && out_ready[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_left[i] <= 0;
                m_hold[i] <= 1'b0;
                m_out[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_hold[i] && out_ready[i]) m_hold[i] <= 1'b0;
                if (m_left[i] == 1) begin
                    m_hold[i] <= 1'b1;
                    m_out[i]  <= m_pend[i];
                end
                if (m_left[i] > 0) m_left[i] <= m_left[i] - 1;
                if (in_valid[i] && m_ready(i)) begin
                    m_pend[i] <= ref_state(in_data, mode, bypass);
                    m_left[i] <= 4 / PC[i];
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("p%0d_out_valid", PC[i]), 128'(out_valid_s[i]), 128'(m_hold[i]));
                check($sformatf("p%0d_in_ready", PC[i]), 128'(in_ready_s[i]), 128'(m_ready(i)));
                if (m_hold[i])
                    check($sformatf("p%0d_out", PC[i]), out_s[i], m_out[i]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns 2 time units after the edge that accepted the state.
    task automatic wait_accept(input int i);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready_s[i];
            @(posedge clk);
        end
        if (!acc) check($sformatf("p%0d_accept_timeout", PC[i]), 128'(0), 128'(1));
        #2;
    endtask

    // Counts edges after acceptance until OUT_VALID is seen; -1 on timeout.
    task automatic wait_result(input int i, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_s[i]) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic run_one(input int i, input logic [127:0] data, input logic m, input logic bp,
                           output logic [127:0] res, output int lat);
        @(posedge clk);
        #2;
        in_data      = data;
        mode         = m;
        bypass       = bp;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b1;
        wait_accept(i);
        in_valid[i] = 1'b0;
        in_data     = ~data;   // sampled only at acceptance
        mode        = ~m;
        bypass      = ~bp;
        wait_result(i, lat);
        res = out_s[i];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] res, res2, rnd, va, vb;
        int           lat;

        rst_n   = 1'b0;
        in_data = '0;
        mode    = 1'b0;
        bypass  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("p%0d_rst_out", PC[i]), out_s[i], '0);
            check($sformatf("p%0d_rst_out_valid", PC[i]), 128'(out_valid_s[i]), 128'(0));
            check($sformatf("p%0d_rst_in_ready", PC[i]), 128'(in_ready_s[i]), 128'(1));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Model pins against literal FIPS-197 columns.
        check("model_fwd", ref_state({4{32'hdb135345}}, 1'b0, 1'b0), {4{32'h8e4da1bc}});
        check("model_inv", ref_state({4{32'h8e4da1bc}}, 1'b1, 1'b0), {4{32'hdb135345}});

        // Forward, P=1.
        run_one(0, {4{32'hdb135345}}, 1'b0, 1'b0, res, lat);
        check("p1_fwd_out", res, {4{32'h8e4da1bc}});
        check("p1_fwd_lat", 128'(lat), 128'(4));

        // Forward, P=4.
        run_one(2, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b0, 1'b0, res, lat);
        check("p4_fwd_out", res, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);
        check("p4_fwd_lat", 128'(lat), 128'(1));

        // Inverse, P=2.
        run_one(1, {4{32'h8e4da1bc}}, 1'b1, 1'b0, res, lat);
        check("p2_inv_out", res, {4{32'hdb135345}});
        check("p2_inv_lat", 128'(lat), 128'(2));

        // Round trips on random states for every width.
        for (int i = 0; i < NI; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_one(i, rnd, 1'b0, 1'b0, res, lat);
            check($sformatf("p%0d_rt_fwd", PC[i]), res, ref_state(rnd, 1'b0, 1'b0));
            run_one(i, res, 1'b1, 1'b0, res2, lat);
            check($sformatf("p%0d_rt_back", PC[i]), res2, rnd);
        end

        // Bypass keeps the state and the latency.
        for (int i = 0; i < NI; i++) begin
            run_one(i, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, res, lat);
            check($sformatf("p%0d_byp_out", PC[i]), res, 128'h00112233445566778899aabbccddeeff);
            check($sformatf("p%0d_byp_lat", PC[i]), 128'(lat), 128'(4 / PC[i]));
        end

        // Backpressure on P=1, then accept-with-release in the same cycle.
        va = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        vb = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        #2;
        in_data      = va;
        mode         = 1'b0;
        bypass       = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        wait_accept(0);
        in_data = vb;          // keep offering the next state during the stall
        wait_result(0, lat);
        check("bp_first_lat", 128'(lat), 128'(4));
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_out", out_s[0], 128'h046681e5_e0cb199a_48f8d37a_2806264c);
            check("bp_hold_in_ready", 128'(in_ready_s[0]), 128'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready_s[0]), 128'(1));
        @(posedge clk);
        #2;
        in_valid[0] = 1'b0;
        wait_result(0, lat);
        check("bp_next_lat", 128'(lat), 128'(4));
        check("bp_next_out", out_s[0], ref_state(vb, 1'b0, 1'b0));

        // Reset while P=1 is in BUSY with cnt=2.
        @(posedge clk);
        #2;
        in_data     = {4{32'hdb135345}};
        mode        = 1'b0;
        bypass      = 1'b0;
        in_valid[0] = 1'b1;
        wait_accept(0);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", out_s[0], '0);
        check("midrst_out_valid", 128'(out_valid_s[0]), 128'(0));
        check("midrst_in_ready", 128'(in_ready_s[0]), 128'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_one(0, va, 1'b0, 1'b0, res, lat);
        check("post_rst_out", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
        check("post_rst_lat", 128'(lat), 128'(4));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
